// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and write-enable masks for the memory access controller.
package mem_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned CNT_WIDTH  = 3;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [3:0] WE_NONE = 4'b0000;
  localparam logic [3:0] WE_BYTE = 4'b0001;
  localparam logic [3:0] WE_HALF = 4'b0011;
  localparam logic [3:0] WE_WORD = 4'b1111;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} ctrlState_e;

  // Size code 11 behaves as a word.
  function automatic logic [3:0] weMask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return WE_BYTE;
      SIZE_HALF: return WE_HALF;
      default:   return WE_WORD;
    endcase
  endfunction

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return offset[0];
      default:   return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bus of the memory access controller.
interface mem_access_ctrl_if
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lane_aligner.sv
// Rotates raw memory lanes so the addressed byte lands in byte 0, then sign/zero extends.
module lane_aligner
  import mem_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rawLanes,
  input  logic [1:0]            offset,
  input  logic [1:0]            size,
  input  logic                  isSigned,
  output logic [DATA_WIDTH-1:0] alignedData_c
);

  logic [DATA_WIDTH-1:0] rotated;

  always_comb begin
    rotated       = DATA_WIDTH'({rawLanes, rawLanes} >> {offset, 3'b000});
    alignedData_c = rotated;
    case (size)
      SIZE_BYTE: alignedData_c = {{24{isSigned & rotated[7]}}, rotated[7:0]};
      SIZE_HALF: alignedData_c = {{16{isSigned & rotated[15]}}, rotated[15:0]};
      default:   ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Requester-side load/store controller for the byte-lane memory manager.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests complete immediately with resp_err.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned RAM_LATENCY = 1
)(
  input  logic                  clk,
  input  logic                  rst,
  mem_access_ctrl_if.slave      bus,
  output logic [DATA_WIDTH-1:0] memaddr,
  output logic [3:0]            writeEnables,
  output logic [DATA_WIDTH-1:0] memin,
  input  logic [DATA_WIDTH-1:0] memout
);

  ctrlState_e            state;
  logic                  reqWrite;
  logic [1:0]            reqSize;
  logic                  reqSigned;
  logic [1:0]            reqOffset;
  logic [CNT_WIDTH-1:0]  latCnt;
  logic [DATA_WIDTH-1:0] alignedData_c;
  logic                  accept_c;
  logic                  misalign_c;

  assign accept_c = bus.req_valid && bus.req_ready;

`ifdef MISALIGN_TRAP_EN
  assign misalign_c = isMisaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign misalign_c = 1'b0;
`endif

  lane_aligner u_laneAligner (
    .rawLanes      (memout),
    .offset        (reqOffset),
    .size          (reqSize),
    .isSigned      (reqSigned),
    .alignedData_c (alignedData_c)
  );

  // Control FSM; every output is registered so the ISSUE cycle already shows the memory command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      memaddr        <= '0;
      writeEnables   <= WE_NONE;
      memin          <= '0;
      latCnt         <= '0;
      reqWrite       <= 1'b0;
      reqSize        <= SIZE_BYTE;
      reqSigned      <= 1'b0;
      reqOffset      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            reqWrite      <= bus.req_write;
            reqSize       <= bus.req_size;
            reqSigned     <= bus.req_signed;
            reqOffset     <= bus.req_addr[1:0];
            bus.req_ready <= 1'b0;
            bus.resp_err  <= 1'b0;
            if (misalign_c) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              state        <= ISSUE;
              memaddr      <= DATA_WIDTH'(bus.req_addr[ADDR_WIDTH-1:0]);
              memin        <= bus.req_wdata;
              writeEnables <= bus.req_write ? weMask(bus.req_size) : WE_NONE;
            end
          end
        end
        ISSUE: begin
          writeEnables <= WE_NONE;
          if (reqWrite) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= '0;
          end else begin
            state  <= WAIT;
            latCnt <= CNT_WIDTH'(RAM_LATENCY);
          end
        end
        WAIT: begin
          // memout for the held address is valid once the count reaches one.
          if (latCnt == CNT_WIDTH'(1)) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= alignedData_c;
            latCnt         <= '0;
          end else begin
            latCnt <= latCnt - CNT_WIDTH'(1);
          end
        end
        RESP: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a latency-accurate byte-lane RAM and a byte-array reference model.
module tb_mem_access_ctrl;

  parameter int unsigned LAT = 3;

  logic        clk;
  logic        rst;
  logic [31:0] memaddr;
  logic [31:0] memin;
  logic [31:0] memout;
  logic [3:0]  writeEnables;

  int checks = 0;
  int failures = 0;

  logic [7:0]  envMem [256];
  logic [7:0]  refMem [256];
  logic [31:0] pipe   [LAT];
  bit          memInit;

  mem_access_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  mem_access_ctrl #(.ADDR_WIDTH(32), .RAM_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .memaddr      (memaddr),
    .writeEnables (writeEnables),
    .memin        (memin),
    .memout       (memout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] pattern(input int i);
    return 8'((i * 167 + 13) ^ (i >> 2));
  endfunction

  // Lane k carries the byte whose address has low bits k, taken from the 4-byte window at a.
  function automatic logic [31:0] laneWord(input logic [31:0] a);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++)
      w[8*k +: 8] = envMem[8'(a + 32'((k + 4 - int'(a[1:0])) % 4))];
    return w;
  endfunction

  // RAM environment: byte writes plus a read pipeline of LAT cycles.
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 256; i++) envMem[i] <= pattern(i);
    end else begin
      for (int i = 0; i < 4; i++)
        if (writeEnables[i]) envMem[8'(memaddr + 32'(i))] <= memin[8*i +: 8];
    end
    pipe[0] <= laneWord(memaddr);
    for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign memout = pipe[LAT-1];

  function automatic int nBytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit isTrap(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [1:0] sz, input bit sg);
    int n;
    logic [31:0] v;
    n = nBytes(sz);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(refMem[8'(a + 32'(i))]) << (8*i));
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic modelStore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    for (int i = 0; i < nBytes(sz); i++) refMem[8'(a + 32'(i))] = wd[8*i +: 8];
  endtask

  // Drives one request and reports what the DUT did; lat stays 0 if no response arrives.
  task automatic runReq(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er, output logic [31:0] iAddr, output logic [3:0] iWe,
                        output logic [31:0] iMemin, output int weCyc, output int pulse);
    int guard;
    lat = 0; rd = 'x; er = 1'bx; weCyc = 0; pulse = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    iAddr = memaddr; iWe = writeEnables; iMemin = memin;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (writeEnables != 4'b0000) weCyc++;
      if (bus.resp_valid === 1'b1) begin lat = n; rd = bus.resp_rdata; er = bus.resp_err; end
    end
    @(negedge clk);
    if (writeEnables != 4'b0000) weCyc++;
    pulse = (bus.resp_valid === 1'b1) ? 2 : 1;
  endtask

  int lat, weC, pulse;
  logic [31:0] rd, iA, iM;
  logic [3:0] iW;
  logic er;

  task automatic test_reset;
    memInit = 1'b1;
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 32'h44; bus.req_wdata = 32'h12345678;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, writeEnables} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_ctrl: got ready/valid/err/we=%b expected 1000000",
               {bus.req_ready, bus.resp_valid, bus.resp_err, writeEnables});
    end
    checks++;
    if ({bus.resp_rdata, memaddr, memin} !== 96'd0) begin
      failures++;
      $display("FAIL reset_data: got rdata=%h memaddr=%h memin=%h expected all 0",
               bus.resp_rdata, memaddr, memin);
    end
    rst = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || writeEnables !== 4'b0000) begin
      failures++;
      $display("FAIL reset_release: got ready=%b we=%b expected 1 0000", bus.req_ready, writeEnables);
    end
    memInit = 1'b0;
  endtask

  task automatic test_store_word;
    runReq(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, iA, iW, iM, weC, pulse);
    modelStore(32'h10, 2'b10, 32'hDEADBEEF);
    checks++;
    if (iA !== 32'h10 || iW !== 4'b1111 || iM !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL store_word_issue: got addr=%h we=%b memin=%h expected 00000010 1111 deadbeef", iA, iW, iM);
    end
    checks++;
    if (lat !== 2 || weC !== 1 || pulse !== 1) begin
      failures++;
      $display("FAIL store_word_timing: got lat=%0d weCycles=%0d pulse=%0d expected 2 1 1", lat, weC, pulse);
    end
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      failures++;
      $display("FAIL store_word_resp: got rdata=%h err=%b expected 0 0", rd, er);
    end
  endtask

  task automatic test_byte_signed;
    runReq(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, lat, rd, er, iA, iW, iM, weC, pulse);
    modelStore(32'h13, 2'b00, 32'h000000A5);
    checks++;
    if (iW !== 4'b0001 || lat !== 2) begin
      failures++;
      $display("FAIL store_byte: got we=%b lat=%0d expected 0001 2", iW, lat);
    end
    runReq(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, er, iA, iW, iM, weC, pulse);
    checks++;
    if (rd !== 32'hFFFFFFA5 || lat !== int'(2 + LAT)) begin
      failures++;
      $display("FAIL load_byte_signed: got rdata=%h lat=%0d expected ffffffa5 %0d", rd, lat, 2 + LAT);
    end
    runReq(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, er, iA, iW, iM, weC, pulse);
    checks++;
    if (rd !== 32'h000000A5 || weC !== 0) begin
      failures++;
      $display("FAIL load_byte_unsigned: got rdata=%h weCycles=%0d expected 000000a5 0", rd, weC);
    end
  endtask

  task automatic test_half_load;
    runReq(1'b1, 2'b10, 1'b0, 32'h20, 32'hBEEF1234, lat, rd, er, iA, iW, iM, weC, pulse);
    modelStore(32'h20, 2'b10, 32'hBEEF1234);
    runReq(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, lat, rd, er, iA, iW, iM, weC, pulse);
    checks++;
    if (rd !== 32'h0000BEEF) begin
      failures++;
      $display("FAIL load_half: got rdata=%h expected 0000beef", rd);
    end
    checks++;
    if (lat !== int'(2 + LAT) || iA !== 32'h22 || pulse !== 1) begin
      failures++;
      $display("FAIL load_half_timing: got lat=%0d addr=%h pulse=%0d expected %0d 00000022 1", lat, iA, pulse, 2 + LAT);
    end
  endtask

  task automatic test_misalign;
    logic [31:0] prevA;
    runReq(1'b1, 2'b10, 1'b0, 32'h20, 32'h44332211, lat, rd, er, iA, iW, iM, weC, pulse);
    modelStore(32'h20, 2'b10, 32'h44332211);
    runReq(1'b1, 2'b10, 1'b0, 32'h24, 32'h88776655, lat, rd, er, iA, iW, iM, weC, pulse);
    modelStore(32'h24, 2'b10, 32'h88776655);
    prevA = memaddr;
    runReq(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, lat, rd, er, iA, iW, iM, weC, pulse);
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      failures++;
      $display("FAIL misalign_trap: got err=%b rdata=%h lat=%0d expected 1 0 1", er, rd, lat);
    end
    checks++;
    if (weC !== 0 || iA !== prevA) begin
      failures++;
      $display("FAIL misalign_nomem: got weCycles=%0d addr=%h expected 0 %h", weC, iA, prevA);
    end
`else
    checks++;
    if (rd !== 32'h55443322 || er !== 1'b0) begin
      failures++;
      $display("FAIL misalign_rotate: got rdata=%h err=%b expected 55443322 0", rd, er);
    end
    checks++;
    if (lat !== int'(2 + LAT) || iA !== 32'h21) begin
      failures++;
      $display("FAIL misalign_pass: got lat=%0d addr=%h expected %0d 00000021", lat, iA, 2 + LAT);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int accepts, resps, lastAcc, badGap;
    logic [31:0] wd;
    wd = $urandom;
    modelStore(32'h40, 2'b10, wd);
    accepts = 0; resps = 0; lastAcc = -1; badGap = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 32'h40; bus.req_wdata = wd;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 20) bus.req_valid = 1'b0;
      if (bus.resp_valid === 1'b1) resps++;
      if (bus.req_valid && bus.req_ready === 1'b1) begin
        if (lastAcc >= 0 && c - lastAcc != 3) badGap++;
        lastAcc = c; accepts++;
      end
    end
    checks++;
    if (accepts !== 7 || resps !== accepts) begin
      failures++;
      $display("FAIL back_to_back_count: got accepts=%0d resps=%0d expected 7 7", accepts, resps);
    end
    checks++;
    if (badGap !== 0) begin
      failures++;
      $display("FAIL back_to_back_gap: got badGaps=%0d expected 0", badGap);
    end
  endtask

  task automatic test_reset_wait;
    int guard, stray;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 32'h30; bus.req_wdata = 32'h0;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (writeEnables !== 4'b0000 || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_wait_state: got we=%b ready=%b expected 0000 1", writeEnables, bus.req_ready);
    end
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.resp_valid !== 1'b0) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL reset_wait_noresp: got respCycles=%0d expected 0", stray);
    end
  endtask

  task automatic test_random;
    bit w, sg, trap;
    logic [1:0] sz;
    logic [31:0] a, wd, expRd, prevA, prevM;
    int expLat;
    for (int t = 0; t < 60; t++) begin
      w = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3)); wd = $urandom;
      a = (t % 10 == 9) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
      trap = isTrap(sz, a);
      expRd = (w || trap) ? 32'h0 : modelLoad(a, sz, sg);
      expLat = trap ? 1 : (w ? 2 : int'(2 + LAT));
      prevA = memaddr; prevM = memin;
      runReq(w, sz, sg, a, wd, lat, rd, er, iA, iW, iM, weC, pulse);
      if (w && !trap) modelStore(a, sz, wd);
      checks++;
      if (lat !== expLat || pulse !== 1) begin
        failures++;
        $display("FAIL rand_timing[%0d]: got lat=%0d pulse=%0d expected %0d 1", t, lat, pulse, expLat);
      end
      checks++;
      if (rd !== expRd || er !== trap) begin
        failures++;
        $display("FAIL rand_resp[%0d]: got rdata=%h err=%b expected %h %b (w=%b sz=%b sg=%b a=%h)",
                 t, rd, er, expRd, trap, w, sz, sg, a);
      end
      checks++;
      if (iA !== (trap ? prevA : a) || iM !== (trap ? prevM : wd)) begin
        failures++;
        $display("FAIL rand_issue[%0d]: got addr=%h memin=%h expected %h %h", t, iA, iM,
                 trap ? prevA : a, trap ? prevM : wd);
      end
      checks++;
      if (iW !== ((w && !trap) ? 4'((1 << nBytes(sz)) - 1) : 4'b0000) || weC !== int'(w && !trap)) begin
        failures++;
        $display("FAIL rand_we[%0d]: got we=%b weCycles=%0d expected mask for %0d bytes, %0d cycles",
                 t, iW, weC, (w && !trap) ? nBytes(sz) : 0, int'(w && !trap));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) refMem[i] = pattern(i);
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_store_word();
    test_byte_signed();
    test_half_load();
    test_misalign();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
